// File: rtl/fifo_pkg.sv
// Shared sizing helpers and parameter legality checks for the team's FIFOs.
package fifo_pkg;

  function automatic int addr_w(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic bit is_pow2(input int v);
    return (v >= 2) && ((v & (v - 1)) == 0);
  endfunction

  function automatic bit params_ok(input int depth, input int af, input int ae);
    return is_pow2(depth) && (af >= 1) && (af <= depth) && (ae >= 0) && (ae <= depth - 1);
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage: one synchronous write port, one asynchronous read port, no reset.
module fifo_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int ADDR_W     = 3
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_W-1:0]     raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/synch_fifo_flags.sv
// Single-clock FIFO with registered full/empty/almost flags, occupancy count,
// overflow/underflow pulses and standard or first-word-fall-through read.
module synch_fifo_flags
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int AF_THRESH  = 6,
  parameter int AE_THRESH  = 2,
  parameter int FWFT       = 0
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    write,
  input  logic [DATA_WIDTH-1:0]   data_in,
  input  logic                    read,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic                    rd_valid,
  output logic                    full,
  output logic                    empty,
  output logic                    almost_full,
  output logic                    almost_empty,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    overflow,
  output logic                    underflow
);

  localparam int ADDR_W = addr_w(DEPTH);
  localparam int CNT_W  = cnt_w(DEPTH);

  if (!params_ok(DEPTH, AF_THRESH, AE_THRESH)) begin : g_param_err
    $error("synch_fifo_flags: illegal DEPTH/AF_THRESH/AE_THRESH combination");
  end

  logic [ADDR_W:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                full_q, full_d, empty_q, empty_d;
  logic                af_q, af_d, ae_q, ae_d;
  logic                ovf_q, ovf_d, udf_q, udf_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                rd_valid_q, rd_valid_d;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                wr_acc, rd_acc;

  // Accept decisions use only registered flags, so full+write+read lets the
  // read through but drops the write, and empty never bypasses data_in.
  assign wr_acc = write & ~full_q;
  assign rd_acc = read & ~empty_q;

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_W     (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .we    (wr_acc & reset_n),
    .waddr (wr_ptr_q[ADDR_W-1:0]),
    .wdata (data_in),
    .raddr (rd_ptr_q[ADDR_W-1:0]),
    .rdata (mem_rdata)
  );

  always_comb begin
    wr_ptr_d   = wr_acc ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = rd_acc ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d    = count_q;
    if (wr_acc && !rd_acc) count_d = count_q + 1'b1;
    if (rd_acc && !wr_acc) count_d = count_q - 1'b1;
    empty_d    = (wr_ptr_d == rd_ptr_d);
    full_d     = (wr_ptr_d[ADDR_W-1:0] == rd_ptr_d[ADDR_W-1:0]) &&
                 (wr_ptr_d[ADDR_W] != rd_ptr_d[ADDR_W]);
    af_d       = (count_d >= CNT_W'(AF_THRESH));
    ae_d       = (count_d <= CNT_W'(AE_THRESH));
    ovf_d      = write & full_q;
    udf_d      = read & empty_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    if (rd_acc) begin
      rd_data_d  = mem_rdata;
      rd_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      af_q       <= 1'b0;
      ae_q       <= 1'b1;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      af_q       <= af_d;
      ae_q       <= ae_d;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // FWFT shows the head word directly; it reads as zero while empty.
  assign data_out     = (FWFT != 0) ? (empty_q ? '0 : mem_rdata) : rd_data_q;
  assign rd_valid     = (FWFT != 0) ? ~empty_q : rd_valid_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

endmodule
